// File: rtl/rv_seq_ctrl.sv
// rv_seq_ctrl: multi-cycle control sequencer for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// generating the one-cycle strobes that capture the instruction, advance or
// redirect the PC and write the register file. Illegal opcodes and memory
// timeouts park the sequencer in a sticky FAULT state until reset.
//
// Ports:
//   clk        system clock, rising edge
//   res        asynchronous active-low reset
//   run        start/continue issuing instructions
//   opcode     instr[6:0] from the instruction register
//   br_taken   branch comparator result (stable EXEC..WB)
//   imem_req   instruction fetch request     imem_ack  fetch data valid
//   dmem_req   data memory request           dmem_we   data request is a store
//   dmem_ack   data access complete
//   ir_en      load instruction register     rf_we     register file write
//   pc_inc     PC += 4                       pc_load   PC <= computed target
//   state      current state encoding        retired   completed instructions
//   fault      sticky error flag
module rv_seq_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             br_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             rf_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Wait counter only needs to reach TIMEOUT-1.
  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt;
  logic             legal;
  logic             is_mem;
  logic             no_rf_write;
  logic             take_target;
  logic             timed_out;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign is_mem      = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign no_rf_write = (opcode == OP_BRANCH) || (opcode == OP_STORE) ||
                       (opcode == OP_FENCE)  || (opcode == OP_SYSTEM);
  assign take_target = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                       ((opcode == OP_BRANCH) && br_taken);

  // Ack in the last permitted cycle is checked before this, so ack wins.
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == WCW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack)       state_d = S_DECODE;
        else if (timed_out) state_d = S_FAULT;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_FAULT;
      S_EXEC:   state_d = is_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack)       state_d = S_WB;
        else if (timed_out) state_d = S_FAULT;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter restarts whenever FETCH or MEM is newly entered.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wait_cnt <= '0;
    end else if ((state_d != state_q) &&
                 ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_cnt <= '0;
    end else if (((state_q == S_FETCH) && !imem_ack) ||
                 ((state_q == S_MEM) && !dmem_ack)) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      retired <= '0;
    end else if (state_q == S_WB) begin
      retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    imem_req = 1'b0;
    ir_en    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_en    = imem_ack;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
      end
      S_WB: begin
        rf_we   = !no_rf_write;
        pc_load = take_target;
        pc_inc  = !take_target;
      end
      default: ;
    endcase
  end

  assign state = state_q;
  assign fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Directed bench for rv_seq_ctrl: main instance with TIMEOUT=4, and a second
// instance with TIMEOUT=0 and a 2-bit retired counter for wrap/no-timeout.
module tb_rv_seq_ctrl;

  logic        clk = 1'b0;
  logic        res;
  logic        run;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        imem_req, imem_ack;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        ir_en, pc_inc, pc_load, rf_we;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        fault;

  logic        run2, imem_ack2;
  logic [6:0]  opcode2;
  logic        br_taken2, dmem_ack2;
  logic        imem_req2, dmem_req2, dmem_we2, ir_en2, pc_inc2, pc_load2, rf_we2;
  logic [2:0]  state2;
  logic [1:0]  retired2;
  logic        fault2;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_ret;
  logic [6:0]  strobes;

  always #5 clk = ~clk;

  // {imem_req, ir_en, dmem_req, dmem_we, pc_inc, pc_load, rf_we}
  assign strobes = {imem_req, ir_en, dmem_req, dmem_we, pc_inc, pc_load, rf_we};

  rv_seq_ctrl #(.TIMEOUT(4), .CNT_W(32)) u_dut (
    .clk(clk), .res(res), .run(run), .opcode(opcode), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .ir_en(ir_en), .pc_inc(pc_inc),
    .pc_load(pc_load), .rf_we(rf_we), .state(state), .retired(retired),
    .fault(fault)
  );

  rv_seq_ctrl #(.TIMEOUT(0), .CNT_W(2)) u_dut2 (
    .clk(clk), .res(res), .run(run2), .opcode(opcode2), .br_taken(br_taken2),
    .imem_req(imem_req2), .imem_ack(imem_ack2), .dmem_req(dmem_req2),
    .dmem_we(dmem_we2), .dmem_ack(dmem_ack2), .ir_en(ir_en2), .pc_inc(pc_inc2),
    .pc_load(pc_load2), .rf_we(rf_we2), .state(state2), .retired(retired2),
    .fault(fault2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    res = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_strobes", 32'(strobes), 32'd0);
    exp_ret = '0;
    tick();
    res = 1'b1;
  endtask

  // Starts and ends in IDLE; checks the WB strobes for a non-memory opcode.
  task automatic run_short(input logic [6:0] op, input logic br, input logic [6:0] exp_wb,
                           input string tag);
    run = 1'b1; opcode = op; br_taken = br; imem_ack = 1'b1;
    tick(); tick(); tick(); tick();
    run = 1'b0;
    samp();
    chk({tag, "_wb_state"}, 32'(state), 32'd5);
    chk({tag, "_wb_strobes"}, 32'(strobes), 32'(exp_wb));
    tick();
    samp();
    chk({tag, "_idle"}, 32'(state), 32'd0);
    exp_ret = exp_ret + 32'd1;
    chk({tag, "_retired"}, retired, exp_ret);
  endtask

  logic [2:0] alu_seq [4] = '{3'd1, 3'd2, 3'd3, 3'd5};

  initial begin
    res = 1'b0; run = 1'b0; opcode = 7'b0010011; br_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    run2 = 1'b0; imem_ack2 = 1'b0; opcode2 = 7'b0010011; br_taken2 = 1'b0;
    dmem_ack2 = 1'b0;
    exp_ret = '0;

    #1;
    chk("init_state", 32'(state), 32'd0);
    chk("init_strobes", 32'(strobes), 32'd0);
    chk("init_fault", 32'(fault), 32'd0);
    tick(); tick();
    res = 1'b1;

    // ALU stream, dmem_ack held high to show it is ignored outside MEM
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) begin
      samp();
      chk("alu_state", 32'(state), 32'(alu_seq[i % 4]));
      chk("alu_pc_inc", 32'(pc_inc), (i % 4 == 3) ? 32'd1 : 32'd0);
      chk("alu_rf_we", 32'(rf_we), (i % 4 == 3) ? 32'd1 : 32'd0);
      chk("alu_ir_en", 32'(ir_en), (i % 4 == 0) ? 32'd1 : 32'd0);
      tick();
    end
    exp_ret = 32'd3;
    chk("alu_retired", retired, exp_ret);

    // Store with two dmem wait cycles, entered straight from the ALU WB
    opcode = 7'b0100011; dmem_ack = 1'b0;
    samp();
    chk("st_fetch", 32'(strobes), 32'(7'b1100000));
    tick(); tick(); tick();
    for (int j = 0; j < 3; j++) begin
      if (j == 2) dmem_ack = 1'b1;
      samp();
      chk("st_mem_state", 32'(state), 32'd4);
      chk("st_mem_strobes", 32'(strobes), 32'(7'b0011000));
      tick();
    end
    run = 1'b0;
    samp();
    chk("st_wb_state", 32'(state), 32'd5);
    chk("st_wb_strobes", 32'(strobes), 32'(7'b0000100));
    tick();
    samp();
    chk("st_idle", 32'(state), 32'd0);
    exp_ret = 32'd4;
    chk("st_retired", retired, exp_ret);

    run_short(7'b1100011, 1'b1, 7'b0000010, "br_taken");
    run_short(7'b1100011, 1'b0, 7'b0000100, "br_not");
    run_short(7'b1101111, 1'b0, 7'b0000011, "jal");
    run_short(7'b1100111, 1'b0, 7'b0000011, "jalr");
    run_short(7'b1110011, 1'b0, 7'b0000100, "system");
    run_short(7'b0001111, 1'b0, 7'b0000100, "fence");
    run_short(7'b0110111, 1'b0, 7'b0000101, "lui");
    run_short(7'b0110011, 1'b1, 7'b0000101, "reg");

    // Load with run dropped in EXEC
    run = 1'b1; opcode = 7'b0000011; imem_ack = 1'b1; dmem_ack = 1'b1;
    tick(); tick(); tick();
    run = 1'b0;
    samp();
    chk("ld_exec", 32'(state), 32'd3);
    tick();
    samp();
    chk("ld_mem_state", 32'(state), 32'd4);
    chk("ld_mem_strobes", 32'(strobes), 32'(7'b0010000));
    tick();
    samp();
    chk("ld_wb_strobes", 32'(strobes), 32'(7'b0000101));
    tick();
    samp();
    chk("ld_idle", 32'(state), 32'd0);
    exp_ret = exp_ret + 32'd1;
    chk("ld_retired", retired, exp_ret);

    // run reasserted: FETCH next cycle; ack arrives in the 4th wait cycle
    run = 1'b1; imem_ack = 1'b0;
    tick();
    samp();
    chk("rerun_fetch", 32'(state), 32'd1);
    tick(); tick(); tick();
    imem_ack = 1'b1;
    samp();
    chk("late_ack_fetch", 32'(state), 32'd1);
    tick();
    samp();
    chk("late_ack_decode", 32'(state), 32'd2);
    chk("late_ack_fault", 32'(fault), 32'd0);
    opcode = 7'b0010011; run = 1'b0;
    tick(); tick(); tick();
    samp();
    chk("late_ack_idle", 32'(state), 32'd0);
    exp_ret = exp_ret + 32'd1;
    chk("late_ack_retired", retired, exp_ret);

    // Fetch timeout: four FETCH cycles, then FAULT with retired frozen
    run = 1'b1; imem_ack = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      samp();
      chk("to_fetch", 32'(state), 32'd1);
      tick();
    end
    samp();
    chk("to_fault_state", 32'(state), 32'd7);
    chk("to_fault_flag", 32'(fault), 32'd1);
    chk("to_fault_strobes", 32'(strobes), 32'd0);
    imem_ack = 1'b1; dmem_ack = 1'b1; run = 1'b0;
    tick(); run = 1'b1; tick(); tick();
    samp();
    chk("to_hold_state", 32'(state), 32'd7);
    chk("to_hold_retired", retired, exp_ret);
    do_reset();

    // MEM timeout on a store whose ack never comes
    run = 1'b1; opcode = 7'b0100011; imem_ack = 1'b1; dmem_ack = 1'b0;
    tick(); tick(); tick(); tick();
    for (int k = 0; k < 4; k++) begin
      samp();
      chk("mto_mem", 32'(state), 32'd4);
      tick();
    end
    samp();
    chk("mto_fault", 32'(state), 32'd7);
    do_reset();

    // Illegal opcode
    run = 1'b1; opcode = 7'b1111111; imem_ack = 1'b1;
    tick(); tick();
    samp();
    chk("ill_decode", 32'(state), 32'd2);
    tick();
    samp();
    chk("ill_state", 32'(state), 32'd7);
    chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_strobes", 32'(strobes), 32'd0);
    tick(); tick();
    samp();
    chk("ill_hold", 32'(state), 32'd7);
    do_reset();

    // Reset during WB kills the pc/rf strobes immediately
    run = 1'b1; opcode = 7'b0010011; imem_ack = 1'b1;
    tick(); tick(); tick(); tick();
    samp();
    chk("midrst_wb", 32'(strobes), 32'(7'b0000101));
    run = 1'b0;
    do_reset();

    // Second instance: no timeout, 2-bit retired counter wraps
    run2 = 1'b1; imem_ack2 = 1'b0;
    tick();
    repeat (20) tick();
    samp();
    chk("nto_state", 32'(state2), 32'd1);
    chk("nto_fault", 32'(fault2), 32'd0);
    imem_ack2 = 1'b1;
    repeat (12) tick();
    samp();
    chk("wrap_ret3", 32'(retired2), 32'd3);
    repeat (4) tick();
    samp();
    chk("wrap_ret0", 32'(retired2), 32'd0);
    chk("wrap_state", 32'(state2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
